// File: rtl/fpga_pkg.sv
// fpga_pkg: shared board constants, timing defaults and scan FSM state encoding
package fpga_pkg;
   localparam int CLK_HZ = 25_000_000;
   localparam int DEF_TICK_DIV = 2500;
   localparam int DEF_STABLE_TICKS = 100;
   typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..DIV-1 and flags the last count as a one-cycle tick
module tick_prescaler #(
   parameter int DIV = 2500
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);
   localparam int W = DIV > 1 ? $clog2(DIV) : 1;
   logic [W-1:0] pre;
   assign tick_o = pre == W'(DIV - 1);
   always_ff @(posedge clk_i)
      if (rst_i || tick_o) pre <= '0;
      else pre <= pre + W'(1);
endmodule

// File: rtl/debounce_scan_scheduler.sv
// debounce_scan_scheduler: debounces N_SW switches with one time-shared counter datapath
module debounce_scan_scheduler
   import fpga_pkg::*;
#(
   parameter int N_SW = 4,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_SW-1:0] sw_i,
   output logic [N_SW-1:0] sw_o,
   output logic [N_SW-1:0] rise_o,
   output logic [N_SW-1:0] fall_o,
   output logic            busy_o
);
   localparam int IW = N_SW > 1 ? $clog2(N_SW) : 1;
   localparam int CW = $clog2(STABLE_TICKS + 1);
   if (TICK_DIV < N_SW + 1) begin : g_bad_div
      $error("TICK_DIV must be at least N_SW+1 so a scan finishes before the next tick");
   end
   logic [N_SW-1:0] sync1, sync2;
   logic [CW-1:0]   cnt [N_SW];
   logic [IW-1:0]   idx, idx_n;
   state_t          state, state_n;
   logic            tick, last, disagree, accept, ch_sync;
   logic [CW-1:0]   ch_cnt;
   tick_prescaler #(.DIV(TICK_DIV)) u_pre (.clk_i(clk_i), .rst_i(rst_i), .tick_o(tick));
   assign busy_o   = state == ST_SCAN;
   assign last     = idx == IW'(N_SW - 1);
   assign ch_sync  = sync2[idx];
   assign ch_cnt   = cnt[idx];
   assign disagree = ch_sync != sw_o[idx];
   assign accept   = busy_o && disagree && ch_cnt == CW'(STABLE_TICKS - 1);
   always_comb begin
      state_n = state;
      idx_n   = idx;
      if (state == ST_IDLE) begin
         state_n = tick ? ST_SCAN : ST_IDLE;
         idx_n   = '0;
      end else begin
         state_n = last ? ST_IDLE : ST_SCAN;
         idx_n   = last ? '0 : idx + IW'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1  <= '0;
         sync2  <= '0;
         sw_o   <= '0;
         rise_o <= '0;
         fall_o <= '0;
         state  <= ST_IDLE;
         idx    <= '0;
         for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
      end else begin
         sync1  <= sw_i;
         sync2  <= sync1;
         state  <= state_n;
         idx    <= idx_n;
         rise_o <= '0;
         fall_o <= '0;
         // only the channel under scan touches the shared compare/increment path
         if (busy_o) begin
            cnt[idx] <= (disagree && !accept) ? ch_cnt + CW'(1) : '0;
            if (accept) begin
               sw_o[idx]   <= ch_sync;
               rise_o[idx] <= ch_sync;
               fall_o[idx] <= !ch_sync;
            end
         end
      end
   end
endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// tb_debounce_scan_scheduler: table, directed and random checks against a behavioural model
module tb_debounce_scan_scheduler;
   localparam int N = 4, TD = 8, ST = 3;
   logic clk = 0, rst = 1;
   logic [3:0] sw = '0;
   logic [3:0] sw_o, rise_o, fall_o;
   logic busy_o;
   int checks = 0, failures = 0;
   int k = 0;
   logic [3:0] m_sw = '0, m_rise = '0, m_fall = '0;
   logic m_busy = 0;
   int m_cnt [4];
   logic [3:0] q [$];
   typedef struct {logic rst; logic [3:0] sw; int n; logic [3:0] exp_sw;} vec_t;
   vec_t tbl [$];

   debounce_scan_scheduler #(.N_SW(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .clk_i(clk), .rst_i(rst), .sw_i(sw), .sw_o(sw_o),
      .rise_o(rise_o), .fall_o(fall_o), .busy_o(busy_o));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
      end
   endtask

   // One clock: model follows the debounce rules by sample-slot arithmetic, then outputs are compared.
   task automatic cycle();
      logic [3:0] s;
      int c;
      @(posedge clk);
      m_rise = '0;
      m_fall = '0;
      if (rst) begin
         k = 0;
         m_sw = '0;
         q = '{4'h0, 4'h0};
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         k++;
         s = q.pop_front();
         q.push_back(sw);
         c = k % TD - 1;
         if (k > TD && c >= 0 && c < N) begin
            if (s[c] != m_sw[c]) begin
               m_cnt[c]++;
               if (m_cnt[c] == ST) begin
                  m_sw[c] = s[c];
                  m_cnt[c] = 0;
                  if (s[c]) m_rise[c] = 1'b1;
                  else m_fall[c] = 1'b1;
               end
            end else m_cnt[c] = 0;
         end
      end
      m_busy = k >= TD && (k % TD) < N;
      @(negedge clk);
      chk("outputs", {3'b0, sw_o, rise_o, fall_o, busy_o}, {3'b0, m_sw, m_rise, m_fall, m_busy});
   endtask

   initial begin
      tbl.push_back('{1'b1, 4'b0000, 2, 4'b0000});
      tbl.push_back('{1'b0, 4'b0000, 100, 4'b0000});
      tbl.push_back('{1'b0, 4'b0001, 40, 4'b0001});
      for (int r = 0; r < 5; r++) begin
         tbl.push_back('{1'b0, 4'b0011, TD, 4'b0001});
         tbl.push_back('{1'b0, 4'b0001, TD, 4'b0001});
      end
      tbl.push_back('{1'b0, 4'b1111, 40, 4'b1111});
      tbl.push_back('{1'b0, 4'b1011, 40, 4'b1011});
      tbl.push_back('{1'b0, 4'b0000, 40, 4'b0000});
      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         sw = tbl[i].sw;
         repeat (tbl[i].n) cycle();
         chk("table_sw", 16'(sw_o), 16'(tbl[i].exp_sw));
      end

      // absolute latency: change present from edge 1 is accepted at edge 25 (slot 0 of the 3rd scan)
      rst = 1;
      cycle();
      rst = 0;
      sw = 4'b0001;
      for (int e = 1; e <= 30; e++) begin
         cycle();
         chk("rise_timing", 16'(rise_o), (k == 25) ? 16'h1 : 16'h0);
         chk("sw0_timing", 16'(sw_o), (k >= 25) ? 16'h1 : 16'h0);
      end

      // reset lands while idx==2 of the accepting scan
      rst = 1;
      cycle();
      rst = 0;
      sw = 4'b1111;
      repeat (26) cycle();
      chk("pre_reset_sw", 16'(sw_o), 16'h3);
      rst = 1;
      cycle();
      chk("reset_mid_scan", {3'b0, sw_o, rise_o, fall_o, busy_o}, 16'h0);
      rst = 0;
      repeat (24) cycle();
      chk("restart_sw", 16'(sw_o), 16'h0);
      cycle();
      chk("restart_rise", 16'(rise_o), 16'h1);
      repeat (3) cycle();
      chk("restart_all", 16'(sw_o), 16'hF);

      for (int r = 0; r < 80; r++) begin
         sw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : sw ^ (4'b1 << $urandom_range(0, 3));
         repeat ($urandom_range(1, 30)) cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
